// File: rtl/lm07_read_sched_pkg.sv
// Shared types and constants for the LM07 temperature read sequencer.
// Holds the FSM encoding, frame field positions and the magnitude rule.
package lm07_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_BCDW  = 3'd4
    } state_e;

    localparam int FRAME_BITS_DEF = 16;
    localparam int TEMP_MSB       = 15;
    localparam int TEMP_LSB       = 8;
    localparam logic [6:0] MAG_SAT = 7'd127;

    // -128 has no 7-bit magnitude, so it pins to the largest representable value.
    function automatic logic [6:0] temp_mag(input logic [7:0] t);
        logic [7:0] neg;
        neg = ~t + 8'd1;
        if (!t[7]) begin
            return t[6:0];
        end else if (t == 8'h80) begin
            return MAG_SAT;
        end else begin
            return neg[6:0];
        end
    endfunction

endpackage

// File: rtl/lm07_read_sched_sck_gen.sv
// SCK divider for the LM07 frame: SCK, per-bit sample strobe and last-fall flag.
// Registered SCK, starts low when enabled; clearing en returns everything to idle.
module lm07_sck_gen #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic sample,
    output logic last_fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bcnt_q, bcnt_d;
    logic             sck_q, sck_d;
    logic             half_end;

    // Sampling happens on the edge that ends a high half-period, i.e. the SCK fall.
    always_comb begin
        half_end  = en && (div_q == DIV_LAST);
        sample    = half_end && sck_q;
        last_fall = sample && (bcnt_q == BIT_LAST);
        div_d     = div_q;
        bcnt_d    = bcnt_q;
        sck_d     = sck_q;
        if (!en) begin
            div_d  = '0;
            bcnt_d = '0;
            sck_d  = 1'b0;
        end else if (half_end) begin
            div_d = '0;
            sck_d = ~sck_q;
            if (sck_q) begin
                bcnt_d = bcnt_q + BIT_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            bcnt_q <= '0;
            sck_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            bcnt_q <= bcnt_d;
            sck_q  <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/lm07_read_sched.sv
// LM07 read sequencer: periodic/on-demand SPI frame capture, latch, bin2BCD handoff.
// Pending-to-BCD_START latency is 1+CS_SETUP+2*CLK_DIV*FRAME_BITS+CS_HOLD; requests coalesce one deep.
module lm07_read_sched
    import lm07_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int PERIOD      = 1000,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int BCD_TIMEOUT = 64
) (
    input  logic        SYSCLK,
    input  logic        RST,
    input  logic        SIO,
    input  logic        RD_REQ,
    output logic        CS,
    output logic        SCK,
    output logic        BUSY,
    output logic        BCD_START,
    output logic [6:0]  BCD_BIN,
    input  logic        BCD_DONE,
    output logic [7:0]  TEMP,
    output logic [15:0] TEMP_RAW,
    output logic        TEMP_VALID,
    output logic        ERR
);

    localparam int CNT_MAX = (BCD_TIMEOUT > CS_SETUP)
                           ? ((BCD_TIMEOUT > CS_HOLD) ? BCD_TIMEOUT : CS_HOLD)
                           : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(BCD_TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             pending_q, pending_d;
    logic [15:0]      shift_q, shift_d;
    logic [15:0]      temp_raw_q, temp_raw_d;
    logic [6:0]       bcd_bin_q, bcd_bin_d;
    logic             temp_valid_q, temp_valid_d;
    logic             bcd_start_q, bcd_start_d;
    logic             err_q, err_d;

    logic sck_en, sck_raw, sample, last_fall;
    logic wrap, leave_idle, hold_done;

    assign sck_en = (state_q == ST_SHIFT);

    lm07_sck_gen #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_sck_gen (
        .clk       (SYSCLK),
        .rst       (RST),
        .en        (sck_en),
        .sck       (sck_raw),
        .sample    (sample),
        .last_fall (last_fall)
    );

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            per_q        <= '0;
            pending_q    <= 1'b0;
            shift_q      <= '0;
            temp_raw_q   <= '0;
            bcd_bin_q    <= '0;
            temp_valid_q <= 1'b0;
            bcd_start_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            per_q        <= per_d;
            pending_q    <= pending_d;
            shift_q      <= shift_d;
            temp_raw_q   <= temp_raw_d;
            bcd_bin_q    <= bcd_bin_d;
            temp_valid_q <= temp_valid_d;
            bcd_start_q  <= bcd_start_d;
            err_q        <= err_d;
        end
    end

    // cnt is shared by SETUP, HOLD and BCDW and is zeroed on every state exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (last_fall) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_BCDW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BCDW: begin
                if (BCD_DONE || (cnt_q == TMO_LAST)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        wrap       = (per_q == PER_LAST);
        per_d      = wrap ? '0 : per_q + PER_W'(1);
        leave_idle = (state_q == ST_IDLE) && pending_q;
        // A request landing on the departure cycle is absorbed by the frame now starting.
        pending_d  = leave_idle ? 1'b0 : (pending_q | wrap | RD_REQ);
        shift_d    = sample ? {shift_q[14:0], SIO} : shift_q;
        hold_done  = (state_q == ST_HOLD) && (cnt_q == HOLD_LAST);
        temp_raw_d = hold_done ? shift_q : temp_raw_q;
        bcd_bin_d  = hold_done ? temp_mag(shift_q[TEMP_MSB:TEMP_LSB]) : bcd_bin_q;
        temp_valid_d = hold_done;
        bcd_start_d  = hold_done;
        err_d = err_q | ((state_q == ST_BCDW) && !BCD_DONE && (cnt_q == TMO_LAST));
    end

    always_comb begin
        CS   = 1'b1;
        SCK  = 1'b0;
        BUSY = 1'b1;
        case (state_q)
            ST_IDLE:  BUSY = 1'b0;
            ST_SETUP: CS = 1'b0;
            ST_SHIFT: begin
                CS  = 1'b0;
                SCK = sck_raw;
            end
            ST_HOLD:  CS = 1'b0;
            ST_BCDW:  BUSY = 1'b1;
            default:  BUSY = 1'b0;
        endcase
    end

    assign TEMP       = temp_raw_q[TEMP_MSB:TEMP_LSB];
    assign TEMP_RAW   = temp_raw_q;
    assign TEMP_VALID = temp_valid_q;
    assign BCD_BIN    = bcd_bin_q;
    assign BCD_START  = bcd_start_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_lm07_read_sched.sv
// Bench for lm07_read_sched: sensor + bin2BCD models, scoreboard of expected frames,
// and a second instance with a short PERIOD for the automatic scheduler.
module tb_lm07_read_sched;

    localparam int CD       = 2;
    localparam int FB       = 16;
    localparam int SETUP    = 2;
    localparam int HOLD     = 2;
    localparam int TMO      = 64;
    localparam int LAT      = 1 + SETUP + 2 * CD * FB + HOLD;
    localparam int CS_LOW   = SETUP + 2 * CD * FB + HOLD;
    localparam int P_PERIOD = 200;

    typedef struct {
        logic [15:0] raw;
        logic [6:0]  bin;
    } exp_t;

    logic        clk;
    logic        rst, sio, rd_req, bcd_done;
    logic        cs, sck, busy, bcd_start, temp_valid, err;
    logic [6:0]  bcd_bin;
    logic [7:0]  temp;
    logic [15:0] temp_raw;

    logic        rst_p, sio_p, rd_req_p, bcd_done_p;
    logic        cs_p, sck_p, busy_p, bcd_start_p, temp_valid_p, err_p;
    logic [6:0]  bcd_bin_p;
    logic [7:0]  temp_p;
    logic [15:0] temp_raw_p;

    int tests = 0;
    int fails = 0;
    int frames_done = 0;
    int frame_rises = 0;
    int sck_bad = 0;
    int aborts_req = 0;
    int p_checks = 0;
    bit bcd_hang = 0;
    logic [6:0] cur_bin = '0;
    logic [15:0] sensor_q[$];
    exp_t exp_q[$];

    lm07_read_sched #(
        .CLK_DIV(CD), .FRAME_BITS(FB), .PERIOD(60000),
        .CS_SETUP(SETUP), .CS_HOLD(HOLD), .BCD_TIMEOUT(TMO)
    ) dut (
        .SYSCLK(clk), .RST(rst), .SIO(sio), .RD_REQ(rd_req),
        .CS(cs), .SCK(sck), .BUSY(busy), .BCD_START(bcd_start),
        .BCD_BIN(bcd_bin), .BCD_DONE(bcd_done), .TEMP(temp),
        .TEMP_RAW(temp_raw), .TEMP_VALID(temp_valid), .ERR(err)
    );

    lm07_read_sched #(
        .CLK_DIV(CD), .FRAME_BITS(FB), .PERIOD(P_PERIOD),
        .CS_SETUP(SETUP), .CS_HOLD(HOLD), .BCD_TIMEOUT(TMO)
    ) dut_p (
        .SYSCLK(clk), .RST(rst_p), .SIO(sio_p), .RD_REQ(rd_req_p),
        .CS(cs_p), .SCK(sck_p), .BUSY(busy_p), .BCD_START(bcd_start_p),
        .BCD_BIN(bcd_bin_p), .BCD_DONE(bcd_done_p), .TEMP(temp_p),
        .TEMP_RAW(temp_raw_p), .TEMP_VALID(temp_valid_p), .ERR(err_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_mag(input logic [15:0] raw);
        int t;
        t = int'(raw[15:8]);
        if (t >= 128) t = t - 256;
        if (t < 0) t = -t;
        if (t > 127) t = 127;
        return 7'(t);
    endfunction

    task automatic chk_reset();
        chk("rst_cs", cs, 1);
        chk("rst_sck", sck, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bcd_start", bcd_start, 0);
        chk("rst_temp_valid", temp_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_temp", temp, 0);
        chk("rst_temp_raw", temp_raw, 0);
        chk("rst_bcd_bin", bcd_bin, 0);
    endtask

    // Issues one host request for a frame carrying raw; returns cycles spent in BCDW.
    task automatic do_frame(input logic [15:0] raw, input bit check_lat, output int bcdw_len);
        int n;
        int target;
        exp_t e;
        e.raw = raw;
        e.bin = ref_mag(raw);
        sensor_q.push_back(raw);
        exp_q.push_back(e);
        target = frames_done + 1;
        rd_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            rd_req = 1'b0;
        end while (!bcd_start && n < 500);
        if (check_lat) chk("req_to_bcd_start_latency", n, LAT + 1);
        bcdw_len = 0;
        while (busy && bcdw_len < 500) begin
            bcdw_len++;
            @(negedge clk);
        end
        chk("frame_completed", frames_done, target);
    endtask

    // Sensor: shifts the queued frame out MSB-first, advancing one bit per SCK fall.
    initial begin
        logic [15:0] cur;
        logic prev_cs, prev_sck;
        int k;
        sio = 1'b0;
        cur = '0;
        prev_cs = 1'b1;
        prev_sck = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            if (cs) begin
                k = 0;
            end else begin
                if (prev_cs) cur = (sensor_q.size() > 0) ? sensor_q.pop_front() : 16'h0000;
                if (prev_sck && !sck) k++;
            end
            sio = (!cs && k < 16) ? cur[15 - k] : 1'b0;
            prev_cs = cs;
            prev_sck = sck;
        end
    end

    // bin2BCD model for the main instance.
    initial begin
        int d;
        bcd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bcd_start && !bcd_hang) begin
                d = $urandom_range(1, 8);
                repeat (d) @(negedge clk);
                chk("bcd_bin_stable_at_done", bcd_bin, cur_bin);
                bcd_done = 1'b1;
                @(negedge clk);
                bcd_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: each BCD_START must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bcd_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_raw", temp_raw, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("temp_valid_with_start", temp_valid, 1);
                    chk("temp_raw", temp_raw, e.raw);
                    chk("temp", temp, e.raw[15:8]);
                    chk("bcd_bin", bcd_bin, e.bin);
                    cur_bin = e.bin;
                end
                frames_done++;
            end else if (temp_valid) begin
                chk("temp_valid_without_start", temp_valid, 0);
            end
        end
    end

    // Framing monitor: CS-low length and SCK pulse count per completed frame.
    initial begin
        logic prev_cs, prev_sck;
        int cs_low, rises, aborts_seen;
        prev_cs = 1'b1;
        prev_sck = 1'b0;
        cs_low = 0;
        rises = 0;
        aborts_seen = 0;
        forever begin
            @(negedge clk);
            if (cs && sck) sck_bad++;
            if (!cs) begin
                cs_low++;
                if (!prev_sck && sck) rises++;
            end else if (!prev_cs) begin
                if (aborts_seen < aborts_req) begin
                    aborts_seen++;
                end else begin
                    chk("cs_low_cycles", cs_low, CS_LOW);
                    chk("sck_pulses", rises, FB);
                end
                cs_low = 0;
                rises = 0;
            end
            frame_rises = rises;
            prev_cs = cs;
            prev_sck = sck;
        end
    end

    // Periodic instance: no host requests, bin2BCD answers after 5 cycles.
    initial begin
        rst_p = 1'b1;
        sio_p = 1'b0;
        rd_req_p = 1'b0;
        bcd_done_p = 1'b0;
        repeat (3) @(negedge clk);
        rst_p = 1'b0;
        forever begin
            @(negedge clk);
            if (bcd_start_p) begin
                repeat (5) @(negedge clk);
                bcd_done_p = 1'b1;
                @(negedge clk);
                bcd_done_p = 1'b0;
            end
        end
    end

    initial begin
        int cyc, last;
        logic prev;
        cyc = 0;
        last = -1;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev && !cs_p) begin
                if (last >= 0) begin
                    chk("period_cs_fall_interval", cyc - last, P_PERIOD);
                    p_checks++;
                end
                last = cyc;
            end
            prev = cs_p;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, n, target;
        rst = 1'b1;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        @(negedge clk);

        do_frame(16'h1980, 1'b1, len);
        chk("t1_temp", temp, 8'h19);
        chk("t1_bcd_bin", bcd_bin, 25);
        do_frame(16'hE700, 1'b1, len);
        chk("t2_temp_neg", temp, 8'hE7);
        chk("t2_bcd_bin_neg", bcd_bin, 25);
        do_frame(16'h8000, 1'b0, len);
        chk("t2_temp_min", temp, 8'h80);
        chk("t2_bcd_bin_sat", bcd_bin, 127);

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_frame(16'($urandom), 1'b0, len);
        end

        // Three requests during SHIFT coalesce into one extra frame.
        begin
            exp_t e;
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            sensor_q.push_back(a);
            sensor_q.push_back(b);
            e.raw = a; e.bin = ref_mag(a); exp_q.push_back(e);
            e.raw = b; e.bin = ref_mag(b); exp_q.push_back(e);
        end
        target = frames_done + 2;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (!sck && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("coalesce_reached_shift", sck, 1);
        repeat (3) begin
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
            repeat (3) @(negedge clk);
        end
        n = 0;
        while (!(frames_done >= target && !busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (300) @(negedge clk);
        chk("coalesce_frame_count", frames_done, target);
        chk("coalesce_idle", busy, 0);

        // bin2BCD never answers: timeout, sticky ERR, next request still served.
        bcd_hang = 1'b1;
        do_frame(16'($urandom), 1'b0, len);
        chk("bcdw_timeout_cycles", len, TMO);
        chk("err_after_timeout", err, 1);
        bcd_hang = 1'b0;
        repeat (4) @(negedge clk);
        do_frame(16'($urandom), 1'b0, len);
        chk("err_sticky", err, 1);

        // Reset mid-frame at the 7th SCK pulse.
        aborts_req++;
        sensor_q.push_back(16'h7FFF);
        target = frames_done;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (frame_rises < 7 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_pulse7", int'(frame_rises >= 7), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset();
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_no_frame", frames_done, target);
        chk("abort_temp_still_zero", temp_raw, 0);
        chk("abort_idle", busy, 0);

        chk("sck_high_while_cs_high", sck_bad, 0);
        chk("periodic_intervals_seen", int'(p_checks >= 5), 1);
        chk("periodic_no_err", err_p, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
